// File: rtl/leaf_port_ingress_buffer.sv
// rtl/leaf_port_ingress_buffer.sv - show-ahead ingress flit FIFO with status, local-dest flag and drop counter
module leaf_port_ingress_buffer #(
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] GROUP_ID   = 4'b0111,
  parameter int         AF_LEVEL   = FIFO_DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DWIDTH-1:0]             in_data,
  input  logic [5:0]                    in_dest_addr,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DWIDTH-1:0]             out_data,
  output logic [5:0]                    out_dest_addr,
  output logic                          out_valid,
  output logic                          out_local,
  input  logic                          out_ready,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          fifo_almost_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 6 + DWIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [7:0]        r_drop;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [EW-1:0]     w_head;
  logic [5:0]        w_head_dest;

  // Occupancy flags come only from the registered count, so a pop cannot free a slot for a same-cycle push
  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (r_count == '0);
  assign w_push      = in_valid & ~w_full;
  assign w_pop       = out_ready & ~w_empty;
  assign w_drop      = in_valid & w_full;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_dest = w_head[EW-1:DWIDTH];

  // Storage array: written on accepted pushes only, never cleared (empty outputs are masked instead)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_dest_addr, in_data};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating count of offers refused because the buffer was full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign in_ready         = ~w_full;
  assign out_valid        = ~w_empty;
  assign out_data         = w_empty ? '0 : w_head[DWIDTH-1:0];
  assign out_dest_addr    = w_empty ? '0 : w_head_dest;
  assign out_local        = ~w_empty && (w_head_dest[5:2] == GROUP_ID);
  assign fifo_full        = w_full;
  assign fifo_empty       = w_empty;
  assign fifo_almost_full = (r_count >= AF_C);
  assign fifo_count       = r_count;
  assign drop_count       = r_drop;

endmodule

// File: tb/tb_leaf_port_ingress_buffer.sv
// tb/tb_leaf_port_ingress_buffer.sv - self-checking bench for leaf_port_ingress_buffer
module tb_leaf_port_ingress_buffer;

  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic [5:0]  in_dest_addr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [5:0]  out_dest_addr;
  logic        out_valid;
  logic        out_local;
  logic        out_ready;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_almost_full;
  logic [3:0]  fifo_count;
  logic [7:0]  drop_count;

  leaf_port_ingress_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .in_data          (in_data),
    .in_dest_addr     (in_dest_addr),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .out_data         (out_data),
    .out_dest_addr    (out_dest_addr),
    .out_valid        (out_valid),
    .out_local        (out_local),
    .out_ready        (out_ready),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .fifo_almost_full (fifo_almost_full),
    .fifo_count       (fifo_count),
    .drop_count       (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of {dest, data} flits and a saturating drop tally
  logic [21:0] mq[$];
  logic [21:0] push_log[$];
  logic [21:0] pop_log[$];
  int          m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int          n;
    logic [21:0] h;
    n = mq.size();
    h = (n > 0) ? mq[0] : 22'd0;
    chk({tag, ".in_ready"},   32'(in_ready),         32'(n < DEPTH));
    chk({tag, ".out_valid"},  32'(out_valid),        32'(n > 0));
    chk({tag, ".out_data"},   32'(out_data),         32'(h[15:0]));
    chk({tag, ".out_dest"},   32'(out_dest_addr),    32'(h[21:16]));
    chk({tag, ".out_local"},  32'(out_local),        32'((n > 0) && (h[21:18] == 4'b0111)));
    chk({tag, ".full"},       32'(fifo_full),        32'(n == DEPTH));
    chk({tag, ".empty"},      32'(fifo_empty),       32'(n == 0));
    chk({tag, ".afull"},      32'(fifo_almost_full), 32'(n >= AF));
    chk({tag, ".count"},      32'(fifo_count),       32'(n));
    chk({tag, ".drops"},      32'(drop_count),       32'(m_drop));
  endtask

  task automatic set_in(input logic v, input logic [15:0] d, input logic [5:0] a, input logic r);
    in_valid     = v;
    in_data      = d;
    in_dest_addr = a;
    out_ready    = r;
  endtask

  // One clock: model decides push/pop from pre-edge inputs and state, then compares after the edge
  task automatic step(input string tag);
    bit          do_push;
    bit          do_pop;
    logic [21:0] f;
    do_push = in_valid && (mq.size() < DEPTH);
    do_pop  = out_ready && (mq.size() > 0);
    f = {in_dest_addr, in_data};
    if (in_valid && !do_push && m_drop < 255) m_drop++;
    @(posedge clk);
    if (do_pop) pop_log.push_back(mq.pop_front());
    if (do_push) begin
      mq.push_back(f);
      push_log.push_back(f);
    end
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    mq.delete();
    m_drop = 0;
    check_all(tag);
    #2 reset = 1'b0;
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    set_in(1'b0, 16'h0, 6'h0, 1'b0);
    #2;
    check_all("por");
    #5 reset = 1'b0;

    // Three flits buffered, then reset mid-cycle
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 16'($urandom), 6'($urandom), 1'b0);
      step("pre_rst");
    end
    chk("pre_rst.count3", 32'(fifo_count), 32'd3);
    set_in(1'b0, 16'h0, 6'h0, 1'b0);
    do_reset("midrst");
    chk("midrst.valid0", 32'(out_valid), 32'd0);
    set_in(1'b1, 16'hA5A5, 6'b011101, 1'b0);
    step("a5a5");
    chk("a5a5.valid", 32'(out_valid), 32'd1);
    chk("a5a5.data",  32'(out_data),  32'hA5A5);
    chk("a5a5.local", 32'(out_local), 32'd1);

    // Drain
    set_in(1'b0, 16'h0, 6'h0, 1'b1);
    step("drain0");

    // Fill and overflow with consumer stalled
    for (int i = 1; i <= 10; i++) begin
      set_in(1'b1, 16'(i), 6'($urandom), 1'b0);
      step("fill");
      if (i == 8) chk("fill.in_ready_after8", 32'(in_ready), 32'd0);
    end
    chk("fill.full",  32'(fifo_full),  32'd1);
    chk("fill.count", 32'(fifo_count), 32'd8);
    chk("fill.drops", 32'(drop_count), 32'd2);
    set_in(1'b0, 16'h0, 6'h0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain.order", 32'(out_data), 32'(i));
      step("drain");
    end
    chk("drain.empty", 32'(fifo_empty), 32'd1);

    // Simultaneous push and pop at count 4
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 16'($urandom), 6'($urandom), 1'b0);
      step("to4");
    end
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 16'($urandom), 6'($urandom), 1'b1);
      step("pp");
      chk("pp.count4", 32'(fifo_count), 32'd4);
    end

    // Full plus pop in the same cycle: offer dropped, count 7
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 16'($urandom), 6'($urandom), 1'b0);
      step("to8");
    end
    chk("to8.full", 32'(fifo_full), 32'd1);
    set_in(1'b1, 16'hBEEF, 6'h3F, 1'b1);
    step("fullpop");
    chk("fullpop.count", 32'(fifo_count), 32'd7);
    chk("fullpop.drops", 32'(drop_count), 32'd3);

    // Pointer wrap: 20 flits, random offers, consumer always ready
    set_in(1'b0, 16'h0, 6'h0, 1'b0);
    do_reset("rst2");
    push_log.delete();
    pop_log.delete();
    cyc = 0;
    while ((push_log.size() < 20 || mq.size() > 0) && cyc < 300) begin
      set_in((push_log.size() < 20) ? 1'($urandom) : 1'b0, 16'($urandom), 6'($urandom), 1'b1);
      step("wrap");
      cyc++;
    end
    chk("wrap.timeout", 32'(cyc < 300), 32'd1);
    chk("wrap.npop", 32'(pop_log.size()), 32'd20);
    for (int i = 0; i < 20 && i < pop_log.size() && i < push_log.size(); i++)
      chk("wrap.order", 32'(pop_log[i]), 32'(push_log[i]));
    chk("wrap.drops0", 32'(drop_count), 32'd0);

    // Local-destination flag on the head flit
    set_in(1'b1, 16'h1111, 6'b011100, 1'b0);
    step("loc1");
    chk("loc1.local", 32'(out_local), 32'd1);
    set_in(1'b0, 16'h0, 6'h0, 1'b1);
    step("loc1pop");
    set_in(1'b1, 16'h2222, 6'b100000, 1'b0);
    step("loc0");
    chk("loc0.local", 32'(out_local), 32'd0);
    chk("loc0.valid", 32'(out_valid), 32'd1);

    // Random mixed traffic
    for (int i = 0; i < 200; i++) begin
      set_in(1'($urandom), 16'($urandom), 6'($urandom), ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1);
      step("rand");
    end

    // Drop counter saturation
    for (int i = 0; i < 300; i++) begin
      set_in(1'b1, 16'($urandom), 6'($urandom), 1'b0);
      step("sat");
    end
    chk("sat.drops", 32'(drop_count), 32'd255);
    step("sat_hold");
    chk("sat_hold.drops", 32'(drop_count), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
